// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM states, sign_mask fields,
// and the alignment predicate used when a request is accepted.
package data_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int SM_UNSIGNED_BIT = 2;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam int MMIO_PRED_W = 1;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_HALF) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU-side load/store bus of the data-memory controller.
// The CPU drives the request fields; the controller returns load data, stall and error.
interface data_mem_ctrl_if;
    logic [31:0] addr_i;
    logic [31:0] w_data_i;
    logic        w_ena_i;
    logic        r_ena_i;
    logic [2:0]  sign_mask_i;
    logic [31:0] r_data_o;
    logic        clk_stall_o;
    logic        err_o;

    modport master (
        output addr_i, w_data_i, w_ena_i, r_ena_i, sign_mask_i,
        input  r_data_o, clk_stall_o, err_o
    );

    modport slave (
        input  addr_i, w_data_i, w_ena_i, r_ena_i, sign_mask_i,
        output r_data_o, clk_stall_o, err_o
    );
endinterface

// File: rtl/data_mem_ctrl_lane_align.sv
// Combinational byte/half/word lane logic: with store=0 extracts and extends a load lane,
// with store=1 merges the store lane into the word leaving the other bytes intact.
module lane_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  sign_mask,
    input  logic        store,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        fill;
    logic [31:0] extracted;
    logic [31:0] merged;

    always_comb begin
        byte_sel  = word[{offset, 3'b000} +: 8];
        half_sel  = offset[1] ? word[31:16] : word[15:0];
        fill      = 1'b0;
        extracted = word;
        merged    = word;
        case (sign_mask[1:0])
            SIZE_BYTE: begin
                fill      = ~sign_mask[SM_UNSIGNED_BIT] & byte_sel[7];
                extracted = {{24{fill}}, byte_sel};
                merged[{offset, 3'b000} +: 8] = data[7:0];
            end
            SIZE_HALF: begin
                fill      = ~sign_mask[SM_UNSIGNED_BIT] & half_sel[15];
                extracted = {{16{fill}}, half_sel};
                if (offset[1]) merged[31:16] = data[15:0];
                else           merged[15:0]  = data[15:0];
            end
            default: begin
                extracted = word;
                merged    = data;
            end
        endcase
        result = store ? merged : extracted;
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory with an LED MMIO register; loads return 3 edges after request,
// stores retire in 3 edges, illegal accesses in 2; clk_stall_o holds the CPU meanwhile.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int BASE_WORD   = 1024,
    parameter int LED_WIDTH   = 8,
    parameter int MMIO_BIT    = 13
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    data_mem_ctrl_if.slave       bus,
    output logic [LED_WIDTH-1:0] led_o
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t               state, state_nx;
    logic [IDX_W-1:0]     idx_q, idx_nx;
    logic                 mmio_q, mmio_nx;
    logic [1:0]           off_q, off_nx;
    logic [31:0]          wdata_q, wdata_nx;
    logic                 we_q, we_nx;
    logic [2:0]           sm_q, sm_nx;
    logic [31:0]          r_data_q, r_data_nx;
    logic [LED_WIDTH-1:0] led_q, led_nx;
    logic                 stall_q, stall_nx;
    logic                 err_q, err_nx;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] ram_word;
    logic [31:0] word_buf;
    logic [31:0] ld_res;
    logic [31:0] st_res;
    logic        mem_we;
    logic        mem_re;

    // Classification of the incoming request; unsigned wrap of the offset lands out of range.
    logic                   req;
    logic [MMIO_PRED_W-1:0] in_mmio;
    logic [29:0]            word_off;
    logic                   illegal;

    assign req      = bus.w_ena_i | bus.r_ena_i;
    assign in_mmio  = ~bus.addr_i[31] & bus.addr_i[MMIO_BIT];
    assign word_off = bus.addr_i[31:2] - 30'(BASE_WORD);
    assign illegal  = misaligned(bus.sign_mask_i[1:0], bus.addr_i[1:0]) ||
                      (!in_mmio && (word_off >= 30'(DEPTH_WORDS)));

    assign word_buf = mmio_q ? 32'(led_q) : ram_word;

    lane_align u_load_align (
        .word      (word_buf),
        .data      (wdata_q),
        .offset    (off_q),
        .sign_mask (sm_q),
        .store     (1'b0),
        .result    (ld_res)
    );

    lane_align u_store_align (
        .word      (word_buf),
        .data      (wdata_q),
        .offset    (off_q),
        .sign_mask (sm_q),
        .store     (1'b1),
        .result    (st_res)
    );

    assign mem_re = (state == ST_FETCH) && !mmio_q;
    assign mem_we = (state == ST_WRITE) && !mmio_q && !rst_i;

    // Single-port RAM: read in FETCH, write-back in WRITE, never reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[idx_q] <= st_res;
        if (mem_re) ram_word <= mem[idx_q];
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx_q;
        mmio_nx   = mmio_q;
        off_nx    = off_q;
        wdata_nx  = wdata_q;
        we_nx     = we_q;
        sm_nx     = sm_q;
        r_data_nx = r_data_q;
        led_nx    = led_q;
        stall_nx  = stall_q;
        err_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    idx_nx   = bus.addr_i[IDX_W+1:2] - IDX_W'(BASE_WORD);
                    mmio_nx  = in_mmio;
                    off_nx   = bus.addr_i[1:0];
                    wdata_nx = bus.w_data_i;
                    we_nx    = bus.w_ena_i;
                    sm_nx    = bus.sign_mask_i;
                    stall_nx = 1'b1;
                    state_nx = illegal ? ST_ERR : ST_FETCH;
                end
            end
            ST_FETCH: state_nx = we_q ? ST_WRITE : ST_READ;
            ST_READ: begin
                r_data_nx = ld_res;
                stall_nx  = 1'b0;
                state_nx  = ST_IDLE;
            end
            ST_WRITE: begin
                if (mmio_q) led_nx = st_res[LED_WIDTH-1:0];
                stall_nx = 1'b0;
                state_nx = ST_IDLE;
            end
            ST_ERR: begin
                err_nx   = 1'b1;
                stall_nx = 1'b0;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            idx_q    <= '0;
            mmio_q   <= 1'b0;
            off_q    <= 2'b00;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            sm_q     <= 3'b000;
            r_data_q <= '0;
            led_q    <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            idx_q    <= idx_nx;
            mmio_q   <= mmio_nx;
            off_q    <= off_nx;
            wdata_q  <= wdata_nx;
            we_q     <= we_nx;
            sm_q     <= sm_nx;
            r_data_q <= r_data_nx;
            led_q    <= led_nx;
            stall_q  <= stall_nx;
            err_q    <= err_nx;
        end
    end

    assign bus.r_data_o    = r_data_q;
    assign bus.clk_stall_o = stall_q;
    assign bus.err_o       = err_q;
    assign led_o           = led_q;
endmodule
